// File: rtl/bayes_array_sequencer.sv
// -----------------------------------------------------------------------------
// bayes_array_sequencer
//
// Sequences one Bayesian inference job on an in-memory-compute array. The job
// loads the LFSR seeds and runs the array in one of two modes:
//   - stochastic (cfg_stoch_log = 0): inference is pulsed for cfg_nsamples
//     cycles, and each row counts the ones it sees on bit_out.
//   - logarithmic (cfg_stoch_log = 1): one inference cycle, then
//     2**NWORD_USED read_out cycles. Each row shifts in its bit_out bit
//     MSB-first to form one likelihood word.
// The per-row results are then held on res_data until res_ready accepts them.
//
// State flow:
//   IDLE -start-> SEED -> RUN -> (READ) -> DRAIN -> DONE -res_ready-> IDLE
//   With cfg_nsamples = 0 in stochastic mode the flow is SEED -> DONE.
//
// Ports
//   clk, rst                  clock (rising edge); asynchronous active-high reset
//   start / busy              job launch (accepted in IDLE only) / job in progress
//   cfg_*                     job configuration, captured when start is accepted
//   inference, load_seed,     array commands. At most one is high in any cycle.
//   read_out
//   read_1, read_8, load_mem  array commands that this block never uses (tied 0)
//   stoch_log, seeds,         registered copies of the configuration, held for
//   adr_full_col/row          the whole job
//   bit_out                   array response, one bit per row. Valid the cycle
//                             after each inference or read_out command.
//   res_data                  16-bit result for each row; row r is in
//                             bits [16r+15:16r]
//   res_valid / res_ready     result handshake
//
// Optional feature (macro BAYES_SEQ_PERF_EN):
//   perf_cycles               number of cycles from the accepted start to the
//                             rise of res_valid. Updated when DONE is entered.
// -----------------------------------------------------------------------------
module bayes_array_sequencer #(
  parameter int NARRAY     = 2,
  parameter int NWORD      = 6,
  parameter int NWORD_USED = 3,
  localparam int N         = NARRAY + NWORD,
  localparam int NROW      = 2 ** NARRAY,
  localparam int SW        = 2 ** NWORD_USED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  input  logic                 cfg_stoch_log,
  input  logic [15:0]          cfg_nsamples,
  input  logic [SW-1:0]        cfg_seeds,
  input  logic [N-1:0]         cfg_col,
  input  logic [N-1:0]         cfg_row,
  output logic                 inference,
  output logic                 load_seed,
  output logic                 read_out,
  output logic                 read_1,
  output logic                 read_8,
  output logic                 load_mem,
  output logic                 stoch_log,
  output logic [SW-1:0]        seeds,
  output logic [N-1:0]         adr_full_col,
  output logic [N-1:0]         adr_full_row,
  input  logic [NROW-1:0]      bit_out,
  output logic [16*NROW-1:0]   res_data,
  output logic                 res_valid,
  input  logic                 res_ready
`ifdef BAYES_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [15:0] nsamples_q;
  logic [15:0] step_cnt;   // cycles left in RUN (stochastic) or READ (log)
  logic        inf_d;      // an inference command was issued last cycle
  logic        rd_d;       // a read_out command was issued last cycle

  assign accept    = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_DONE);
  assign read_1    = 1'b0;
  assign read_8    = 1'b0;
  assign load_mem  = 1'b0;

  // NOTE: sequential state uses non-blocking (<=) assignments. Every register
  // then updates from the values present before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each output of this block gets a default before the case statement.
  // Without the defaults, a path that does not assign an output would infer
  // a latch.
  always_comb begin
    state_nxt = state;
    inference = 1'b0;
    load_seed = 1'b0;
    read_out  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEED;
      S_SEED: begin
        load_seed = 1'b1;
        if (!stoch_log && (nsamples_q == 16'd0)) state_nxt = S_DONE;
        else                                     state_nxt = S_RUN;
      end
      S_RUN: begin
        inference = 1'b1;
        if (stoch_log)                state_nxt = S_READ;
        else if (step_cnt == 16'd1)   state_nxt = S_DRAIN;
      end
      S_READ: begin
        read_out = 1'b1;
        if (step_cnt == 16'd1) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration capture, step counter and per-row accumulators.
  // res_data is itself the accumulator. It is cleared on the accepting edge,
  // so it starts from zero when SEED is entered and stops changing once the
  // last delayed sample has been taken on the edge into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stoch_log    <= 1'b0;
      seeds        <= '0;
      adr_full_col <= '0;
      adr_full_row <= '0;
      nsamples_q   <= '0;
      step_cnt     <= '0;
      inf_d        <= 1'b0;
      rd_d         <= 1'b0;
      res_data     <= '0;
    end else begin
      inf_d <= inference;
      rd_d  <= read_out;
      if (accept) begin
        stoch_log    <= cfg_stoch_log;
        seeds        <= cfg_seeds;
        adr_full_col <= cfg_col;
        adr_full_row <= cfg_row;
        nsamples_q   <= cfg_nsamples;
        step_cnt     <= cfg_nsamples;
        res_data     <= '0;
      end else begin
        if (state == S_RUN) begin
          // In log mode the counter is reloaded here to time the READ phase.
          if (stoch_log) step_cnt <= 16'(SW);
          else           step_cnt <= step_cnt - 16'd1;
        end else if (state == S_READ) begin
          step_cnt <= step_cnt - 16'd1;
        end

        for (int r = 0; r < NROW; r++) begin
          if (inf_d && !stoch_log && bit_out[r])
            res_data[16*r +: 16] <= res_data[16*r +: 16] + 16'd1;
          else if (rd_d && stoch_log)
            res_data[16*r +: 16] <= {res_data[16*r +: 15], bit_out[r]};
        end
      end
    end
  end

`ifdef BAYES_SEQ_PERF_EN
  logic [31:0] run_cnt;

  // run_cnt counts the cycles since the accepted start. The cycle that enters
  // DONE is the one where res_valid rises, so that cycle is added in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt     <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept)    run_cnt <= 32'd1;
      else if (busy) run_cnt <= run_cnt + 32'd1;
      if ((state_nxt == S_DONE) && (state != S_DONE))
        perf_cycles <= run_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bayes_array_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for bayes_array_sequencer.
// The per-cycle bit_out stimulus of each job is stored in bo[], indexed by the
// cycle number counted from the cycle in which start is driven.
// The reference model works directly from the job schedule:
//   - stochastic: the samples are taken in cycles 3 .. nsamples+2
//   - log: the samples are taken in cycles 4 .. 2**NWORD_USED+3
// -----------------------------------------------------------------------------
module tb_bayes_array_sequencer;

  localparam int NARRAY     = 2;
  localparam int NWORD      = 6;
  localparam int NWORD_USED = 3;
  localparam int N          = NARRAY + NWORD;
  localparam int NROW       = 2 ** NARRAY;
  localparam int SW         = 2 ** NWORD_USED;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                busy;
  logic                cfg_stoch_log;
  logic [15:0]         cfg_nsamples;
  logic [SW-1:0]       cfg_seeds;
  logic [N-1:0]        cfg_col, cfg_row;
  logic                inference, load_seed, read_out;
  logic                read_1, read_8, load_mem;
  logic                stoch_log;
  logic [SW-1:0]       seeds;
  logic [N-1:0]        adr_full_col, adr_full_row;
  logic [NROW-1:0]     bit_out;
  logic [16*NROW-1:0]  res_data;
  logic                res_valid;
  logic                res_ready;
`ifdef BAYES_SEQ_PERF_EN
  logic [31:0]         perf_cycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  logic [NROW-1:0] bo [0:127];

  bayes_array_sequencer #(
    .NARRAY(NARRAY), .NWORD(NWORD), .NWORD_USED(NWORD_USED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .cfg_stoch_log(cfg_stoch_log), .cfg_nsamples(cfg_nsamples),
    .cfg_seeds(cfg_seeds), .cfg_col(cfg_col), .cfg_row(cfg_row),
    .inference(inference), .load_seed(load_seed), .read_out(read_out),
    .read_1(read_1), .read_8(read_8), .load_mem(load_mem),
    .stoch_log(stoch_log), .seeds(seeds),
    .adr_full_col(adr_full_col), .adr_full_row(adr_full_row),
    .bit_out(bit_out), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready)
`ifdef BAYES_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-row results, computed from the sampling schedule.
  function automatic logic [63:0] model(input bit log_mode, input int ns);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < NROW; r++) begin
      int acc;
      acc = 0;
      if (!log_mode) begin
        for (int c = 3; c < 3 + ns; c++) acc += int'(bo[c][r]);
      end else begin
        for (int c = 4; c < 4 + SW; c++) acc = acc * 2 + int'(bo[c][r]);
      end
      v[16*r +: 16] = acc[15:0];
    end
    return v;
  endfunction

  // Runs one job from the posedge+1 point and checks it, then holds DONE for
  // hold_cycles with res_ready low (pulsing start once), releases the
  // result, and returns the result observed in DONE.
  task automatic run_job(input string name, input bit log_mode, input logic [15:0] ns,
                         input int hold_cycles, output logic [63:0] res_o);
    logic [SW-1:0] sd;
    logic [N-1:0]  col, row;
    logic [63:0]   exp;
    int lat, infc, ldc, rdc, overlap, hold_bad, done_bad, exp_lat;
    sd  = SW'($urandom);
    col = N'($urandom);
    row = N'($urandom);
    lat = 0; infc = 0; ldc = 0; rdc = 0; overlap = 0; hold_bad = 0; done_bad = 0;
    exp_lat = log_mode ? SW + 4 : ((ns == 16'd0) ? 2 : int'(ns) + 3);
    exp = model(log_mode, int'(ns));

    cfg_stoch_log = log_mode;
    cfg_nsamples  = ns;
    cfg_seeds     = sd;
    cfg_col       = col;
    cfg_row       = row;
    start         = 1'b1;
    bit_out       = bo[0];
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start         = 1'b0;
      cfg_stoch_log = 1'($urandom);
      cfg_nsamples  = 16'($urandom);
      cfg_seeds     = SW'($urandom);
      cfg_col       = N'($urandom);
      cfg_row       = N'($urandom);
      bit_out       = bo[k];
      if (inference) infc++;
      if (load_seed) ldc++;
      if (read_out)  rdc++;
      if (int'(inference) + int'(load_seed) + int'(read_out) > 1) overlap++;
      if (read_1 || read_8 || load_mem) overlap++;
      if (stoch_log !== log_mode || seeds !== sd || adr_full_col !== col ||
          adr_full_row !== row || busy !== 1'b1) hold_bad++;
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    res_o = 64'(res_data);
    check({name, ".latency"},   64'(lat),      64'(exp_lat));
    check({name, ".inference"}, 64'(infc),     log_mode ? 64'd1 : 64'(ns));
    check({name, ".load_seed"}, 64'(ldc),      64'd1);
    check({name, ".read_out"},  64'(rdc),      log_mode ? 64'(SW) : 64'd0);
    check({name, ".cmd_excl"},  64'(overlap),  64'd0);
    check({name, ".cfg_hold"},  64'(hold_bad), 64'd0);
    check({name, ".res_data"},  res_o,         exp);
`ifdef BAYES_SEQ_PERF_EN
    check({name, ".perf"}, 64'(perf_cycles), 64'(exp_lat));
`endif

    for (int i = 0; i < hold_cycles; i++) begin
      if (i == hold_cycles / 2) start = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      bit_out = NROW'($urandom);
      if (res_valid !== 1'b1 || busy !== 1'b1 || 64'(res_data) !== exp) done_bad++;
    end
    if (hold_cycles > 0) check({name, ".done_hold"}, 64'(done_bad), 64'd0);

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, ".idle_after_ready"}, {62'd0, busy, res_valid}, 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    logic [7:0]  seq;

    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    cfg_stoch_log = 1'b0; cfg_nsamples = '0; cfg_seeds = '0;
    cfg_col = '0; cfg_row = '0; bit_out = '0;
    #12;
    check("reset.ctrl", {55'd0, inference, load_seed, read_out, read_1, read_8,
                         load_mem, busy, res_valid, stoch_log}, 64'd0);
    check("reset.cfg", {40'd0, seeds, adr_full_col, adr_full_row}, 64'd0);
    check("reset.res_data", 64'(res_data), 64'd0);
`ifdef BAYES_SEQ_PERF_EN
    check("reset.perf", 64'(perf_cycles), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Stochastic job: 4 samples with bit_out held at 4'b0101.
    for (int c = 0; c < 128; c++) bo[c] = 4'b0101;
    run_job("stoch4", 1'b0, 16'd4, 0, res);
    check("stoch4.rows", res, {16'd0, 16'd4, 16'd0, 16'd4});

    // Log mode job: row 0 sees the bit sequence 1,0,1,1,0,0,1,0.
    seq = 8'b1011_0010;
    for (int c = 0; c < 128; c++) bo[c] = NROW'($urandom);
    for (int i = 0; i < SW; i++) bo[4 + i][0] = seq[7 - i];
    run_job("log", 1'b1, 16'd0, 0, res);
    check("log.row0", res[15:0], 16'h00B2);

    // Zero samples: there is no RUN phase, so all results stay 0.
    for (int c = 0; c < 128; c++) bo[c] = NROW'($urandom);
    run_job("ns0", 1'b0, 16'd0, 0, res);
    check("ns0.rows", res, 64'd0);

    // DONE held for 10 cycles with res_ready low and start pulsed.
    for (int c = 0; c < 128; c++) bo[c] = NROW'($urandom);
    run_job("hold", 1'b0, 16'd6, 10, res);

    // Random jobs in both modes.
    for (int j = 0; j < 6; j++) begin
      for (int c = 0; c < 128; c++) bo[c] = NROW'($urandom);
      run_job($sformatf("rand%0d", j), 1'($urandom),
              16'($urandom_range(1, 20)), int'($urandom_range(0, 3)), res);
    end

    // Reset asserted mid-RUN: the outputs must clear before the next clock edge.
    cfg_stoch_log = 1'b0; cfg_nsamples = 16'd20; cfg_seeds = 8'hA5;
    cfg_col = 8'h3C; cfg_row = 8'hC3; bit_out = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("midrun.busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("midrun.ctrl", {55'd0, inference, load_seed, read_out, read_1, read_8,
                          load_mem, busy, res_valid, stoch_log}, 64'd0);
    check("midrun.cfg", {40'd0, seeds, adr_full_col, adr_full_row}, 64'd0);
    check("midrun.res_data", 64'(res_data), 64'd0);
`ifdef BAYES_SEQ_PERF_EN
    check("midrun.perf", 64'(perf_cycles), 64'd0);
`endif
    #5;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 128; c++) bo[c] = NROW'($urandom);
    run_job("after_rst", 1'b0, 16'd5, 0, res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bayes_array_sequencer.md
BAYES_ARRAY_SEQUENCER -- requirements
Module: bayes_array_sequencer

Interface
REQ-001 SHALL have parameter NARRAY, default 2, array address width (2**NARRAY rows/cols).
REQ-002 SHALL have parameter NWORD, default 6, per-memory address width; N = NARRAY+NWORD.
REQ-003 SHALL have parameter NWORD_USED, default 3, likelihood data width exponent (2**NWORD_USED-bit words).
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch one inference job.
- busy  out  1  job in progress.
- cfg_stoch_log  in  1  0 stochastic, 1 logarithmic.
- cfg_nsamples  in  16  stochastic sample count.
- cfg_seeds  in  2**NWORD_USED  LFSR seeds.
- cfg_col, cfg_row  in  N each  observation addresses.
- inference, load_seed, read_out  out  1 each  array commands.
- read_1, read_8, load_mem  out  1 each  array commands, tied 0.
- stoch_log  out  1  registered copy of cfg_stoch_log.
- seeds  out  2**NWORD_USED  registered copy of cfg_seeds.
- adr_full_col, adr_full_row  out  N each  registered addresses.
- bit_out  in  2**NARRAY  array response.
- res_data  out  16*2**NARRAY  per-row result, row r in bits [16r+15:16r].
- res_valid  in/out: out  1  result valid; res_ready  in  1  result accepted.

Function
REQ-005 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-006 SHALL capture all cfg_* inputs on the accepting cycle and hold them constant on the array-facing outputs until return to IDLE.
REQ-007 SHALL implement states IDLE, SEED, RUN, DRAIN, READ, DONE.
REQ-008 SHALL sequence IDLE -start-> SEED (1 cycle, load_seed=1) -> RUN.
REQ-009 Stochastic RUN SHALL assert inference for exactly cfg_nsamples consecutive cycles, then enter DRAIN for 1 cycle with all commands low.
REQ-010 SHALL treat bit_out as valid the cycle after each inference cycle; in stochastic mode, per-row 16-bit counter r increments when bit_out[r]=1 in that cycle (cycles after the first RUN cycle through DRAIN).
REQ-011 cfg_nsamples=0 SHALL skip RUN and DRAIN (SEED -> DONE) with all counters 0.
REQ-012 Log RUN SHALL assert inference for 1 cycle, then READ asserts read_out for 2**NWORD_USED cycles.
REQ-013 In log mode, each row SHALL shift bit_out[r] in MSB-first, sampling the cycle after each read_out cycle; result zero-extended to 16 bits; one DRAIN cycle follows READ.
REQ-014 DONE SHALL assert res_valid with res_data stable until res_ready=1; exit to IDLE on that cycle.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Counters/shift registers SHALL clear on entering SEED.
REQ-017 At most one of inference, load_seed, read_out SHALL be high in any cycle.

Reset
REQ-018 rst SHALL force IDLE immediately, asynchronously, including mid-job.
REQ-019 During/after reset all outputs SHALL be 0: commands, stoch_log, seeds, addresses, res_data, res_valid, busy.

Configuration
REQ-020 Macro BAYES_SEQ_PERF_EN defined SHALL add output perf_cycles (32 bits): cycles from accepted start to res_valid rise, reset 0, updated on DONE entry.
REQ-021 Without BAYES_SEQ_PERF_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-022 Stochastic, nsamples=4, bit_out=4'b0101 constant -> load_seed 1 cycle, inference 4 cycles, rows 0,2 = 4, rows 1,3 = 0, res_valid 7 cycles after start.
REQ-023 Log mode, bit_out row0 sequence 1,0,1,1,0,0,1,0 -> row0 result 16'h00B2, read_out high exactly 8 cycles.
REQ-024 nsamples=0 -> no inference pulse, res_valid 2 cycles after start, all results 0.
REQ-025 res_ready held 0 for 10 cycles in DONE, start pulsed -> res_data stable, start ignored; res_ready=1 -> IDLE next cycle.
REQ-026 rst asserted mid-RUN -> all outputs 0 without waiting for clk; next start runs a clean job with counters from 0.
REQ-027 With BAYES_SEQ_PERF_EN, nsamples=4 stochastic -> perf_cycles=7.
